timing_sequencer: RTL and testbench

//  Two-phase timing sequencer for MCS-4 counter and latch chains. Divides sysclk into
//  non-overlapping phi1/phi2 slots, issues the step_a/step_b strobes that advance

---
 rtl/timing_sequencer.sv | 106 ++++++++++
 tb/tb_timing_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/timing_sequencer.sv
// Two-phase MCS-4 timing sequencer: divides sysclk into phi1/phi2 slots, issues
// step_a/step_b counter strobes and walks the 8-subcycle instruction cycle with SYNC.
module timing_sequencer #(
  parameter int unsigned SLOT_LEN = 4
) (
  input  logic       sysclk,
  input  logic       reset_n,
  input  logic       run,
  input  logic       step_req,
  output logic       clk1,
  output logic       clk2,
  output logic       step_a,
  output logic       step_b,
  output logic [2:0] subcycle,
  output logic       sync,
  output logic       cycle_done,
  output logic       busy
);

  localparam int unsigned DIV_W = (SLOT_LEN > 1) ? $clog2(SLOT_LEN) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SLOT_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_SINGLE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] w_div_nxt;
  logic [1:0]       r_slot;
  logic [1:0]       w_slot_nxt;
  logic [2:0]       r_sub;
  logic [2:0]       w_sub_nxt;
  logic             w_div_wrap;
  logic             w_slot_wrap;
  logic             w_cycle_end;
  logic             w_active_nxt;

  // Next-state and counter chain; run is only consulted at the cycle boundary.
  always_comb begin
    w_state_nxt = r_state;
    w_div_nxt   = r_div;
    w_slot_nxt  = r_slot;
    w_sub_nxt   = r_sub;
    w_div_wrap  = (r_div == DIV_LAST);
    w_slot_wrap = w_div_wrap && (r_slot == 2'd3);
    w_cycle_end = (r_state != ST_IDLE) && w_slot_wrap && (r_sub == 3'd7);
    case (r_state)
      ST_IDLE: begin
        w_div_nxt  = '0;
        w_slot_nxt = 2'd0;
        w_sub_nxt  = 3'd0;
        if (run) begin
          w_state_nxt = ST_RUN;
        end else if (step_req) begin
          w_state_nxt = ST_SINGLE;
        end
      end
      default: begin
        w_div_nxt  = w_div_wrap ? '0 : r_div + DIV_W'(1);
        w_slot_nxt = w_div_wrap ? r_slot + 2'd1 : r_slot;
        w_sub_nxt  = w_slot_wrap ? r_sub + 3'd1 : r_sub;
        if (w_cycle_end) begin
          w_state_nxt = run ? ST_RUN : ST_IDLE;
        end
      end
    endcase
    w_active_nxt = (w_state_nxt != ST_IDLE);
  end

  // Outputs are decoded from the next counter values so they line up with the state.
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_div      <= '0;
      r_slot     <= 2'd0;
      r_sub      <= 3'd0;
      clk1       <= 1'b0;
      clk2       <= 1'b0;
      step_a     <= 1'b0;
      step_b     <= 1'b0;
      subcycle   <= 3'd0;
      sync       <= 1'b0;
      cycle_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_div      <= w_div_nxt;
      r_slot     <= w_slot_nxt;
      r_sub      <= w_sub_nxt;
      clk1       <= w_active_nxt && (w_slot_nxt == 2'd0);
      clk2       <= w_active_nxt && (w_slot_nxt == 2'd2);
      step_a     <= w_active_nxt && (w_slot_nxt == 2'd0) && (w_div_nxt == DIV_LAST);
      step_b     <= w_active_nxt && (w_slot_nxt == 2'd2) && (w_div_nxt == DIV_LAST);
      subcycle   <= w_sub_nxt;
      sync       <= w_active_nxt && (w_sub_nxt == 3'd7);
      cycle_done <= w_active_nxt && (w_sub_nxt == 3'd7) && (w_slot_nxt == 2'd3) &&
                    (w_div_nxt == DIV_LAST);
      busy       <= w_active_nxt;
    end
  end

endmodule

// File: tb/tb_timing_sequencer.sv
// Bench for timing_sequencer: three instances (SLOT_LEN 4/2/1) against a position-based model.
module tb_timing_sequencer;

  logic       sysclk = 1'b0;
  logic       reset_n = 1'b0;
  logic       run = 1'b0;
  logic       step_req = 1'b0;
  logic [2:0] c1, c2, sa, sb, sy, cd, bz;
  logic [2:0] sc [3];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 sysclk = ~sysclk;

  timing_sequencer #(.SLOT_LEN(4)) u_dut4 (
    .sysclk(sysclk), .reset_n(reset_n), .run(run), .step_req(step_req),
    .clk1(c1[0]), .clk2(c2[0]), .step_a(sa[0]), .step_b(sb[0]), .subcycle(sc[0]),
    .sync(sy[0]), .cycle_done(cd[0]), .busy(bz[0]));
  timing_sequencer #(.SLOT_LEN(2)) u_dut2 (
    .sysclk(sysclk), .reset_n(reset_n), .run(run), .step_req(step_req),
    .clk1(c1[1]), .clk2(c2[1]), .step_a(sa[1]), .step_b(sb[1]), .subcycle(sc[1]),
    .sync(sy[1]), .cycle_done(cd[1]), .busy(bz[1]));
  timing_sequencer #(.SLOT_LEN(1)) u_dut1 (
    .sysclk(sysclk), .reset_n(reset_n), .run(run), .step_req(step_req),
    .clk1(c1[2]), .clk2(c2[2]), .step_a(sa[2]), .step_b(sb[2]), .subcycle(sc[2]),
    .sync(sy[2]), .cycle_done(cd[2]), .busy(bz[2]));

  function automatic int len_of(input int k);
    return (k == 0) ? 4 : ((k == 1) ? 2 : 1);
  endfunction

  // Model: 0=idle 1=run 2=single, plus a flat sysclk position inside the instruction cycle.
  int m_st [3];
  int m_pos [3];

  always @(posedge sysclk or negedge reset_n) begin
    for (int k = 0; k < 3; k++) begin
      if (!reset_n) begin
        m_st[k]  <= 0;
        m_pos[k] <= 0;
      end else if (m_st[k] == 0) begin
        m_pos[k] <= 0;
        m_st[k]  <= run ? 1 : (step_req ? 2 : 0);
      end else if (m_pos[k] == 32 * len_of(k) - 1) begin
        m_pos[k] <= 0;
        m_st[k]  <= run ? 1 : 0;
      end else begin
        m_pos[k] <= m_pos[k] + 1;
      end
    end
  end

  function automatic logic [9:0] exp_vec(input int st, input int pos, input int len);
    logic act;
    int   dv, sl, sub;
    act = (st != 0);
    dv  = pos % len;
    sl  = (pos / len) % 4;
    sub = act ? pos / (4 * len) : 0;
    return {act && sl == 0, act && sl == 2, act && sl == 0 && dv == len - 1,
            act && sl == 2 && dv == len - 1, 3'(sub), act && sub == 7,
            act && pos == 32 * len - 1, act};
  endfunction

  function automatic logic [9:0] dut_vec(input int k);
    return {c1[k], c2[k], sa[k], sb[k], sc[k], sy[k], cd[k], bz[k]};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s actual=%0d (0x%0h) required=%0d (0x%0h) t=%0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  // Per-cycle comparison of every instance against the model.
  always @(negedge sysclk) begin
    for (int k = 0; k < 3; k++) begin
      check($sformatf("outputs_len%0d", len_of(k)), int'(dut_vec(k)),
            int'(exp_vec(m_st[k], m_pos[k], len_of(k))));
    end
    check("phase_overlap", int'(c1 & c2), 0);
  end

  // Two chained master/slave counter stages stepped by the SLOT_LEN=1 instance.
  logic m0, m1, s0, s1;
  always @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      m0 <= 1'b0; m1 <= 1'b0; s0 <= 1'b0; s1 <= 1'b0;
    end else begin
      if (sa[2]) begin
        m0 <= ~s0;
        m1 <= s1 ^ s0;
      end
      if (sb[2]) begin
        s0 <= m0;
        s1 <= m1;
      end
    end
  end

  task automatic do_reset();
    @(negedge sysclk);
    reset_n  = 1'b0;
    run      = 1'b0;
    step_req = 1'b0;
    @(negedge sysclk);
    reset_n = 1'b1;
  endtask

  int cnt_a [3];
  int cnt_b [3];
  int cnt_d [3];
  int qa [$];
  int qb [$];
  int qd [$];
  int sync_cnt, tog0, tog1, busy127, busy128, sub_m2;
  logic p0, p1;

  initial begin
    repeat (2) @(negedge sysclk);
    reset_n = 1'b1;

    // T1: async reset mid-RUN at M2 of the SLOT_LEN=4 instance
    do_reset();
    run = 1'b1;
    for (int t = 0; t < 70; t++) begin
      @(negedge sysclk);
      sub_m2 = int'(sc[0]);
    end
    check("t1_at_m2", sub_m2, 4);
    #1 reset_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) check($sformatf("t1_reset_len%0d", len_of(k)), int'(dut_vec(k)), 0);
    run = 1'b0;
    @(negedge sysclk);
    reset_n = 1'b1;
    repeat (5) @(negedge sysclk);
    check("t1_stays_idle", int'(bz), 0);

    // T3: run dropped during A3 (SLOT_LEN=4 offset 37)
    do_reset();
    run = 1'b1;
    for (int k = 0; k < 3; k++) cnt_d[k] = 0;
    for (int t = 0; t < 200; t++) begin
      @(negedge sysclk);
      for (int k = 0; k < 3; k++) cnt_d[k] += int'(cd[k]);
      if (t == 127) busy127 = int'(bz[0]);
      if (t == 128) busy128 = int'(bz[0]);
      if (t == 37) run = 1'b0;
    end
    check("t3_done_len4", cnt_d[0], 1);
    check("t3_done_len2", cnt_d[1], 1);
    check("t3_done_len1", cnt_d[2], 2);
    check("t3_busy_x3", busy127, 1);
    check("t3_busy_after", busy128, 0);
    check("t3_idle_all", int'(bz), 0);

    // T4: single step, with a repeated request during SINGLE
    do_reset();
    step_req = 1'b1;
    for (int k = 0; k < 3; k++) begin cnt_a[k] = 0; cnt_b[k] = 0; cnt_d[k] = 0; end
    for (int t = 0; t < 140; t++) begin
      @(negedge sysclk);
      for (int k = 0; k < 3; k++) begin
        cnt_a[k] += int'(sa[k]);
        cnt_b[k] += int'(sb[k]);
        cnt_d[k] += int'(cd[k]);
      end
      step_req = (t == 10);
    end
    for (int k = 0; k < 3; k++) begin
      check($sformatf("t4_step_a_len%0d", len_of(k)), cnt_a[k], 8);
      check($sformatf("t4_step_b_len%0d", len_of(k)), cnt_b[k], 8);
      check($sformatf("t4_done_len%0d", len_of(k)), cnt_d[k], 1);
    end
    check("t4_idle_all", int'(bz), 0);

    // T2/T5/T6: run and step_req together, free-running strobe timing and counter chain
    do_reset();
    run      = 1'b1;
    step_req = 1'b1;
    sync_cnt = 0; tog0 = 0; tog1 = 0; cnt_d[2] = 0;
    p0 = 1'b0; p1 = 1'b0;
    for (int t = 0; t < 140; t++) begin
      @(negedge sysclk);
      step_req = 1'b0;
      if (sa[1]) qa.push_back(t);
      if (sb[1]) qb.push_back(t);
      if (cd[1]) qd.push_back(t);
      if (t < 128) sync_cnt += int'(sy[1]);
      cnt_d[2] += int'(cd[2]);
      if (t < 64) begin
        tog0 += int'(s0 != p0);
        tog1 += int'(s1 != p1);
      end
      p0 = s0; p1 = s1;
      if (t == 135) check("t5_still_running", int'(bz[0]), 1);
    end
    check("t2_step_a_0", qa[0], 1);
    check("t2_step_a_1", qa[1], 9);
    check("t2_step_a_2", qa[2], 17);
    check("t2_step_b_0", qb[0], 5);
    check("t2_step_b_1", qb[1], 13);
    check("t2_done_0", qd[0], 63);
    check("t2_done_1", qd[1], 127);
    check("t2_sync_count", sync_cnt, 16);
    check("t5_done_len1", cnt_d[2], 4);
    check("t6_stage0_toggles", tog0, 16);
    check("t6_stage1_toggles", tog1, 8);
    run = 1'b0;
    repeat (140) @(negedge sysclk);
    check("t5_parked", int'(bz), 0);

    // Randomized run / step_req / occasional reset, checked by the per-cycle compare
    for (int t = 0; t < 4000; t++) begin
      @(negedge sysclk);
      if ($urandom_range(39) == 0) run = ~run;
      step_req = ($urandom_range(15) == 0);
      reset_n  = ($urandom_range(499) != 0);
    end
    reset_n = 1'b1;
    @(negedge sysclk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
